ffre_misr: RTL and testbench

FFRE_MISR -- requirements
Module: ffre_misr

---
 rtl/ffre_misr.sv | 140 ++++++++++++++
 tb/tb_ffre_misr.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ffre_misr.sv
// Multiple-input signature register that folds a flop-bank output vector into a 32-bit CRC-style signature over a counted capture run.
// Optional macro FFRE_MISR_CMP_EN adds an expected-signature compare with registered pass/fail outputs.
module ffre_misr #(
  parameter int DW = 101,
  parameter int SW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic [CW-1:0] len,
  input  logic [0:DW-1] din,
  input  logic          din_vld,
`ifdef FFRE_MISR_CMP_EN
  input  logic [SW-1:0] exp_sig,
`endif
  output logic          busy,
  output logic          done,
  output logic [SW-1:0] sig,
  output logic [CW-1:0] cnt
`ifdef FFRE_MISR_CMP_EN
  ,
  output logic          pass,
  output logic          fail
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [SW-1:0] POLY = 32'h04C11DB7;
  localparam logic [SW-1:0] SEED = 32'hFFFFFFFF;
  localparam int NCH = (DW + 31) / 32;
  localparam int PW  = NCH * 32;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] sig_q, sig_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] cnt_inc;
  logic [SW-1:0] sig_step;
  logic [SW-1:0] fold;
  logic [0:PW-1] din_pad;

  // Pad at the high-index end so the last chunk carries zeros beyond DW.
  generate
    if (PW > DW) begin : g_pad
      assign din_pad = {din, {(PW - DW){1'b0}}};
    end else begin : g_nopad
      assign din_pad = din;
    end
  endgenerate

  // Column gi of every chunk lands on fold bit 31-gi (bit-reversed within a chunk).
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_fold
      logic [NCH-1:0] col;
      for (genvar gk = 0; gk < NCH; gk++) begin : g_chunk
        assign col[gk] = din_pad[32*gk + gi];
      end
      assign fold[31-gi] = ^col;
    end
  endgenerate

  assign cnt_inc  = cnt_q + 1'b1;
  assign sig_step = {sig_q[SW-2:0], 1'b0} ^ (sig_q[SW-1] ? POLY : '0) ^ fold;

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sig_d   = SEED;
          cnt_d   = '0;
          len_d   = len;
          state_d = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (din_vld) begin
          sig_d = sig_step;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sig  = sig_q;
  assign cnt  = cnt_q;

`ifdef FFRE_MISR_CMP_EN
  logic pass_q, pass_d, fail_q, fail_d;

  // Evaluated on next-state values so the verdict appears together with done.
  always_comb begin
    pass_d = 1'b0;
    fail_d = 1'b0;
    if (state_d == DONE) begin
      pass_d = (sig_d == exp_sig);
      fail_d = !pass_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
      fail_q <= fail_d;
    end
  end

  assign pass = pass_q;
  assign fail = fail_q;
`endif

endmodule

// File: tb/tb_ffre_misr.sv
// Directed self-checking bench for ffre_misr; covers the compare outputs when FFRE_MISR_CMP_EN is defined.
module tb_ffre_misr;
  localparam int DW = 101;
  localparam int SW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] len = '0;
  logic [0:DW-1] din = '0;
  logic          din_vld = 1'b0;
  logic          busy, done;
  logic [SW-1:0] sig;
  logic [CW-1:0] cnt;
`ifdef FFRE_MISR_CMP_EN
  logic [SW-1:0] exp_sig = '0;
  logic          pass, fail;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ffre_misr #(.DW(DW), .SW(SW), .CW(CW)) dut (
    .clk(clk), .clr(clr), .start(start), .len(len), .din(din), .din_vld(din_vld),
`ifdef FFRE_MISR_CMP_EN
    .exp_sig(exp_sig),
`endif
    .busy(busy), .done(done), .sig(sig), .cnt(cnt)
`ifdef FFRE_MISR_CMP_EN
    , .pass(pass), .fail(fail)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-16s observed %h expected %h", tag, obs, exp);
  endtask

  // Start a len=1 run capturing vector v; leaves the DUT in DONE.
  task automatic run1(input logic [0:DW-1] v);
    start = 1'b1; len = 16'd1;
    step();
    start = 1'b0; din = v; din_vld = 1'b1;
    step();
    din_vld = 1'b0; din = '0;
  endtask

  initial begin
    logic [0:DW-1] v;

    // Reset
    step();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_sig", sig, 32'hFFFFFFFF);
    check("rst_cnt", {16'b0, cnt}, 32'd0);
    clr = 1'b1;
    step();

    // len=0 goes straight to DONE
    start = 1'b1; len = '0;
    step();
    start = 1'b0;
    check("len0_done", {31'b0, done}, 32'd1);
    check("len0_busy", {31'b0, busy}, 32'd0);
    check("len0_sig", sig, 32'hFFFFFFFF);
    check("len0_cnt", {16'b0, cnt}, 32'd0);

    // len=1, din=0 (start from DONE must clear done)
`ifdef FFRE_MISR_CMP_EN
    exp_sig = 32'hFB3EE249;
`endif
    start = 1'b1; len = 16'd1;
    step();
    start = 1'b0;
    check("l1_busy", {31'b0, busy}, 32'd1);
    check("l1_done_clr", {31'b0, done}, 32'd0);
    check("l1_sig_seed", sig, 32'hFFFFFFFF);
    din = '0; din_vld = 1'b1;
    step();
    din_vld = 1'b0;
    check("l1_done", {31'b0, done}, 32'd1);
    check("l1_sig", sig, 32'hFB3EE249);
    check("l1_cnt", {16'b0, cnt}, 32'd1);
`ifdef FFRE_MISR_CMP_EN
    check("cmp_pass1", {31'b0, pass}, 32'd1);
    check("cmp_fail0", {31'b0, fail}, 32'd0);
`endif
    // DONE holds despite activity on din
    din = '1; din_vld = 1'b1;
    step(); step();
    din_vld = 1'b0; din = '0;
    check("hold_done", {31'b0, done}, 32'd1);
    check("hold_sig", sig, 32'hFB3EE249);
    check("hold_cnt", {16'b0, cnt}, 32'd1);

`ifdef FFRE_MISR_CMP_EN
    exp_sig = 32'h0;
    run1('0);
    check("cmp_pass0", {31'b0, pass}, 32'd0);
    check("cmp_fail1", {31'b0, fail}, 32'd1);
`endif

    // Single-bit folds
    v = '0; v[0] = 1'b1;
    run1(v);
    check("bit0_sig", sig, 32'h7B3EE249);
    v = '0; v[100] = 1'b1;
    run1(v);
    check("bit100_sig", sig, 32'hF33EE249);

    // len=3, vld pattern 1,0,1,1; start during RUN is ignored
    start = 1'b1; len = 16'd3;
    step();
    start = 1'b0; din = '0; din_vld = 1'b1;
    step();
    check("l3_c1_sig", sig, 32'hFB3EE249);
    check("l3_c1_cnt", {16'b0, cnt}, 32'd1);
    din = '1; din_vld = 1'b0; start = 1'b1; len = '0;
    step();
    start = 1'b0; din = '0;
    check("l3_stall_sig", sig, 32'hFB3EE249);
    check("l3_stall_cnt", {16'b0, cnt}, 32'd1);
    check("l3_stall_busy", {31'b0, busy}, 32'd1);
    din_vld = 1'b1;
    step();
    check("l3_c2_sig", sig, 32'hF2BCD925);
    check("l3_c2_done", {31'b0, done}, 32'd0);
    step();
    din_vld = 1'b0;
    check("l3_done", {31'b0, done}, 32'd1);
    check("l3_sig", sig, 32'hE1B8AFFD);
    check("l3_cnt", {16'b0, cnt}, 32'd3);

    // Reset aborts a run mid-way
    start = 1'b1; len = 16'd3;
    step();
    start = 1'b0; din_vld = 1'b1;
    step();
    clr = 1'b0;
    step();
    clr = 1'b1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_sig", sig, 32'hFFFFFFFF);
    check("abort_cnt", {16'b0, cnt}, 32'd0);
    step(); step(); step();
    din_vld = 1'b0;
    check("abort_no_done", {31'b0, done}, 32'd0);
    check("abort_idle_sig", sig, 32'hFFFFFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
